// File: rtl/stopwatch_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_bcd
//  Description : MM:SS stopwatch. Counts rising edges of the Hz divider square
//                wave as seconds in four BCD digits, under start/stop and
//                clear pulse control. Wraps or saturates at the top count.
//  Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_bcd #(
    parameter int c_MIN_LIMIT   = 100,  // minute modulus, legal 1..100
    parameter bit c_HOLD_AT_MAX = 1'b0  // 0 = wrap to 00:00, 1 = saturate
) (
    input  logic        i_CLK,
    input  logic        i_RST_N,
    input  logic        i_Tick,
    input  logic        i_Start_Stop,
    input  logic        i_Clear,
    output logic [15:0] o_Digits,
    output logic        o_Running,
    output logic        o_Rollover
);

    // Highest displayable time: (c_MIN_LIMIT-1):59 in BCD.
    localparam int          c_MAX_MIN    = c_MIN_LIMIT - 1;
    localparam logic [15:0] c_MAX_DIGITS = {4'(c_MAX_MIN / 10),
                                            4'(c_MAX_MIN % 10),
                                            4'd5, 4'd9};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] digits_q, digits_d;
    logic        rollover_q, rollover_d;
    logic        r_Tick_Q;

    logic        w_Edge;
    logic        w_count;
    logic        w_at_max;
    logic [15:0] w_digits_inc;

    // Rising-edge detect on the divider output; combinational in the same cycle.
    assign w_Edge   = i_Tick & ~r_Tick_Q;
    assign w_count  = (state_q == RUN) && w_Edge && !i_Clear;
    assign w_at_max = (digits_q == c_MAX_DIGITS);

    // Delay stage for the tick edge detector.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            r_Tick_Q <= 1'b0;
        end else begin
            r_Tick_Q <= i_Tick;
        end
    end

    // BCD carry chain: value one second after the current digits. The minute
    // overflow past the limit never occurs here because the max-count case is
    // intercepted before this value is used.
    always_comb begin
        w_digits_inc = digits_q;
        if (digits_q[3:0] != 4'd9) begin
            w_digits_inc[3:0] = digits_q[3:0] + 4'd1;
        end else begin
            w_digits_inc[3:0] = 4'd0;
            if (digits_q[7:4] != 4'd5) begin
                w_digits_inc[7:4] = digits_q[7:4] + 4'd1;
            end else begin
                w_digits_inc[7:4] = 4'd0;
                if (digits_q[11:8] != 4'd9) begin
                    w_digits_inc[11:8] = digits_q[11:8] + 4'd1;
                end else begin
                    w_digits_inc[11:8]  = 4'd0;
                    w_digits_inc[15:12] = digits_q[15:12] + 4'd1;
                end
            end
        end
    end

    // Next-state, next-digits and rollover pulse; clear beats start/stop,
    // which beats the saturate-at-max pause.
    always_comb begin
        state_d    = state_q;
        digits_d   = digits_q;
        rollover_d = 1'b0;

        if (i_Clear) begin
            state_d  = IDLE;
            digits_d = 16'h0000;
        end else begin
            if (w_count) begin
                if (w_at_max) begin
                    if (c_HOLD_AT_MAX) begin
                        // Already saturated: digits frozen, silently pause.
                        state_d = PAUSE;
                    end else begin
                        digits_d   = 16'h0000;
                        rollover_d = 1'b1;
                    end
                end else begin
                    digits_d = w_digits_inc;
                    if (c_HOLD_AT_MAX && (w_digits_inc == c_MAX_DIGITS)) begin
                        rollover_d = 1'b1;
                        state_d    = PAUSE;
                    end
                end
            end

            if (i_Start_Stop) begin
                case (state_q)
                    IDLE:    state_d = RUN;
                    RUN:     state_d = PAUSE;
                    PAUSE:   state_d = RUN;
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // State, digit and pulse registers.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_q    <= IDLE;
            digits_q   <= 16'h0000;
            rollover_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            digits_q   <= digits_d;
            rollover_q <= rollover_d;
        end
    end

    assign o_Digits   = digits_q;
    assign o_Running  = (state_q == RUN);
    assign o_Rollover = rollover_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stopwatch_bcd
//  Description : Directed self-checking bench for stopwatch_bcd. Three
//                instances: default wrap, saturate-at-max, 60-minute limit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_bcd;

    logic        clk;
    logic        rst_n;
    logic        tick0, ss0, clr0;
    logic        tick1, ss1, clr1;
    logic        tick2, ss2, clr2;
    logic [15:0] dig0, dig1, dig2;
    logic        run0, run1, run2;
    logic        rol0, rol1, rol2;

    int checks;
    int failures;

    stopwatch_bcd #(.c_MIN_LIMIT(100), .c_HOLD_AT_MAX(1'b0)) u_wrap (
        .i_CLK(clk), .i_RST_N(rst_n), .i_Tick(tick0), .i_Start_Stop(ss0),
        .i_Clear(clr0), .o_Digits(dig0), .o_Running(run0), .o_Rollover(rol0));

    stopwatch_bcd #(.c_MIN_LIMIT(100), .c_HOLD_AT_MAX(1'b1)) u_hold (
        .i_CLK(clk), .i_RST_N(rst_n), .i_Tick(tick1), .i_Start_Stop(ss1),
        .i_Clear(clr1), .o_Digits(dig1), .o_Running(run1), .o_Rollover(rol1));

    stopwatch_bcd #(.c_MIN_LIMIT(60), .c_HOLD_AT_MAX(1'b0)) u_min60 (
        .i_CLK(clk), .i_RST_N(rst_n), .i_Tick(tick2), .i_Start_Stop(ss2),
        .i_Clear(clr2), .o_Digits(dig2), .o_Running(run2), .o_Rollover(rol2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every nibble of every instance must stay a legal BCD digit.
    always @(negedge clk) begin
        logic [47:0] all;
        all = {dig2, dig1, dig0};
        for (int n = 0; n < 12; n++) begin
            checks++;
            if (!(all[n*4 +: 4] <= 4'd9)) begin
                failures++;
                $display("FAIL bcd_nibble: nibble %0d of digits = %h, required <= 9", n, all[n*4 +: 4]);
            end
        end
    end

    function automatic logic [15:0] to_bcd(input int secs);
        int m, s;
        m = secs / 60;
        s = secs % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int idx, input logic t, input logic s, input logic c);
        case (idx)
            0:       begin tick0 = t; ss0 = s; clr0 = c; end
            1:       begin tick1 = t; ss1 = s; clr1 = c; end
            default: begin tick2 = t; ss2 = s; clr2 = c; end
        endcase
    endtask

    task automatic tick_n(input int idx, input int n);
        for (int k = 0; k < n; k++) begin
            drive(idx, 1'b1, 1'b0, 1'b0);
            step();
            drive(idx, 1'b0, 1'b0, 1'b0);
            step();
        end
    endtask

    task automatic pulse_ss(input int idx);
        drive(idx, 1'b0, 1'b1, 1'b0);
        step();
        drive(idx, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulse_clr(input int idx);
        drive(idx, 1'b0, 1'b0, 1'b1);
        step();
        drive(idx, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0);
        drive(2, 1'b0, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({dig0, dig1, dig2} !== 48'h0 || {run0, run1, run2} !== 3'b000 || {rol0, rol1, rol2} !== 3'b000) begin
            failures++;
            $display("FAIL reset_outputs: digits=%h/%h/%h run=%b%b%b rol=%b%b%b, required all zero",
                     dig0, dig1, dig2, run0, run1, run2, rol0, rol1, rol2);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_count10();
        pulse_ss(0);
        checks++;
        if (run0 !== 1'b1 || dig0 !== 16'h0000) begin
            failures++;
            $display("FAIL start_run: run=%b digits=%h, required run=1 digits=0000", run0, dig0);
        end
        // Latency: digits unchanged while tick is high before the edge is clocked.
        drive(0, 1'b1, 1'b0, 1'b0);
        #2;
        checks++;
        if (dig0 !== 16'h0000) begin
            failures++;
            $display("FAIL latency_pre: digits=%h, required 0000", dig0);
        end
        step();
        checks++;
        if (dig0 !== 16'h0001) begin
            failures++;
            $display("FAIL latency_post: digits=%h, required 0001", dig0);
        end
        drive(0, 1'b0, 1'b0, 1'b0);
        step();
        tick_n(0, 9);
        checks++;
        if (dig0 !== 16'h0010 || run0 !== 1'b1 || rol0 !== 1'b0) begin
            failures++;
            $display("FAIL ten_ticks: digits=%h run=%b rol=%b, required 0010 run=1 rol=0", dig0, run0, rol0);
        end
    endtask

    task automatic test_carry();
        tick_n(0, 49);
        checks++;
        if (dig0 !== 16'h0059) begin
            failures++;
            $display("FAIL at_0059: digits=%h, required 0059", dig0);
        end
        tick_n(0, 1);
        checks++;
        if (dig0 !== 16'h0100) begin
            failures++;
            $display("FAIL sec_carry: digits=%h, required 0100", dig0);
        end
        tick_n(0, 539);
        checks++;
        if (dig0 !== 16'h0959) begin
            failures++;
            $display("FAIL at_0959: digits=%h, required 0959", dig0);
        end
        drive(0, 1'b1, 1'b0, 1'b0);
        step();
        checks++;
        if (dig0 !== 16'h1000 || rol0 !== 1'b0) begin
            failures++;
            $display("FAIL min_carry: digits=%h rol=%b, required 1000 rol=0", dig0, rol0);
        end
        drive(0, 1'b0, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_wrap();
        tick_n(0, 5399);
        checks++;
        if (dig0 !== to_bcd(5999)) begin
            failures++;
            $display("FAIL at_9959: digits=%h, required 9959", dig0);
        end
        drive(0, 1'b1, 1'b0, 1'b0);
        step();
        checks++;
        if (dig0 !== 16'h0000 || rol0 !== 1'b1 || run0 !== 1'b1) begin
            failures++;
            $display("FAIL wrap: digits=%h rol=%b run=%b, required 0000 rol=1 run=1", dig0, rol0, run0);
        end
        drive(0, 1'b0, 1'b0, 1'b0);
        step();
        checks++;
        if (rol0 !== 1'b0) begin
            failures++;
            $display("FAIL wrap_pulse_width: rol=%b, required 0", rol0);
        end
    endtask

    task automatic test_hold();
        pulse_ss(1);
        tick_n(1, 5998);
        checks++;
        if (dig1 !== 16'h9958 || run1 !== 1'b1) begin
            failures++;
            $display("FAIL hold_pre: digits=%h run=%b, required 9958 run=1", dig1, run1);
        end
        drive(1, 1'b1, 1'b0, 1'b0);
        step();
        checks++;
        if (dig1 !== 16'h9959 || rol1 !== 1'b1 || run1 !== 1'b0) begin
            failures++;
            $display("FAIL hold_reach: digits=%h rol=%b run=%b, required 9959 rol=1 run=0", dig1, rol1, run1);
        end
        drive(1, 1'b0, 1'b0, 1'b0);
        step();
        checks++;
        if (rol1 !== 1'b0) begin
            failures++;
            $display("FAIL hold_pulse_width: rol=%b, required 0", rol1);
        end
        tick_n(1, 2);
        pulse_ss(1);
        checks++;
        if (run1 !== 1'b1 || dig1 !== 16'h9959) begin
            failures++;
            $display("FAIL hold_restart: run=%b digits=%h, required run=1 9959", run1, dig1);
        end
        drive(1, 1'b1, 1'b0, 1'b0);
        step();
        checks++;
        if (dig1 !== 16'h9959 || run1 !== 1'b0 || rol1 !== 1'b0) begin
            failures++;
            $display("FAIL hold_repause: digits=%h run=%b rol=%b, required 9959 run=0 rol=0", dig1, run1, rol1);
        end
        drive(1, 1'b0, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_same_cycle();
        pulse_clr(0);
        pulse_ss(0);
        tick_n(0, 5);
        checks++;
        if (dig0 !== 16'h0005) begin
            failures++;
            $display("FAIL sc_0005: digits=%h, required 0005", dig0);
        end
        drive(0, 1'b1, 1'b1, 1'b0);
        step();
        checks++;
        if (dig0 !== 16'h0006 || run0 !== 1'b0) begin
            failures++;
            $display("FAIL sc_stop_and_tick: digits=%h run=%b, required 0006 run=0", dig0, run0);
        end
        drive(0, 1'b0, 1'b0, 1'b0);
        step();
        tick_n(0, 5);
        checks++;
        if (dig0 !== 16'h0006) begin
            failures++;
            $display("FAIL sc_paused: digits=%h, required 0006", dig0);
        end
        // Start coinciding with an edge while paused: resume, tick not counted.
        drive(0, 1'b1, 1'b1, 1'b0);
        step();
        checks++;
        if (dig0 !== 16'h0006 || run0 !== 1'b1) begin
            failures++;
            $display("FAIL sc_resume_and_tick: digits=%h run=%b, required 0006 run=1", dig0, run0);
        end
        drive(0, 1'b0, 1'b0, 1'b0);
        step();
        tick_n(0, 1);
        checks++;
        if (dig0 !== 16'h0007 || run0 !== 1'b1) begin
            failures++;
            $display("FAIL sc_0007: digits=%h run=%b, required 0007 run=1", dig0, run0);
        end
    endtask

    task automatic test_clear();
        pulse_clr(0);
        checks++;
        if (dig0 !== 16'h0000 || run0 !== 1'b0) begin
            failures++;
            $display("FAIL clear_basic: digits=%h run=%b, required 0000 run=0", dig0, run0);
        end
        pulse_ss(0);
        tick_n(0, 42);
        checks++;
        if (dig0 !== 16'h0042) begin
            failures++;
            $display("FAIL clear_pre: digits=%h, required 0042", dig0);
        end
        drive(0, 1'b1, 1'b1, 1'b1);
        step();
        checks++;
        if (dig0 !== 16'h0000 || run0 !== 1'b0 || rol0 !== 1'b0) begin
            failures++;
            $display("FAIL clear_wins: digits=%h run=%b rol=%b, required 0000 run=0 rol=0", dig0, run0, rol0);
        end
        drive(0, 1'b0, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_min60();
        pulse_ss(2);
        tick_n(2, 3599);
        checks++;
        if (dig2 !== 16'h5959) begin
            failures++;
            $display("FAIL min60_max: digits=%h, required 5959", dig2);
        end
        drive(2, 1'b1, 1'b0, 1'b0);
        step();
        checks++;
        if (dig2 !== 16'h0000 || rol2 !== 1'b1) begin
            failures++;
            $display("FAIL min60_wrap: digits=%h rol=%b, required 0000 rol=1", dig2, rol2);
        end
        drive(2, 1'b0, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_async_reset();
        pulse_ss(0);
        tick_n(0, 3);
        checks++;
        if (dig0 !== 16'h0003 || run0 !== 1'b1) begin
            failures++;
            $display("FAIL ar_pre: digits=%h run=%b, required 0003 run=1", dig0, run0);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (dig0 !== 16'h0000 || run0 !== 1'b0 || dig1 !== 16'h0000 || rol0 !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: digits=%h/%h run=%b rol=%b, required 0000/0000 run=0 rol=0",
                     dig0, dig1, run0, rol0);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_count10();
        test_carry();
        test_wrap();
        test_hold();
        test_same_cycle();
        test_clear();
        test_min60();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
